sprite_animator: RTL
====================

// Module: sprite_animator
// PURPOSE
//  Parametrised box-sprite animation engine driving the VGA adapter pixel port (x, y, colour, plot).
//  Repeatedly draws a BOX_W x BOX_H sprite, holds it for a programmable number of frame ticks,
//  erases it to background, then moves it one pixel per axis.
//  Supports wrap and bounce edge modes. Sits between top-level switch/key inputs and the vga_adapter.
// PARAMETERS
//  X_W             8        x coordinate width
//  Y_W             7        y coordinate width
//  SCREEN_W        160      visible columns
//  SCREEN_H        120      visible rows
//  BOX_W           4        sprite width, pixels (>=1)
//  BOX_H           4        sprite height, pixels (>=1)
//  FRAME_DIV       833334   clock cycles per frame tick (50 MHz / 60 Hz)
//  FRAMES_PER_STEP 4        frame ticks the sprite is held before erase (>=1)
//  BG_COLOUR       3'b000   erase colour
// PORTS
//  clock       in   1    system clock
//  reset_n     in   1    synchronous, active-low reset
//  load        in   1    latch x_in/y_in/colour_in/x_dir_in/y_dir_in (IDLE only)
//  go          in   1    start animation (IDLE only)
//  stop        in   1    request stop; latched, honoured after next ERASE
//  mode        in   1    0 = wrap, 1 = bounce; sampled in MOVE
//  x_in        in   X_W  start x
//  y_in        in   Y_W  start y
//  colour_in   in   3    sprite colour
//  x_dir_in    in   1    0 = +x, 1 = -x
//  y_dir_in    in   1    0 = +y, 1 = -y
//  x_out       out  X_W  pixel x to adapter
//  y_out       out  Y_W  pixel y to adapter
//  colour_out  out  3    pixel colour to adapter
//  plot        out  1    write-enable to adapter
//  busy        out  1    high in every state except IDLE
//  step_pulse  out  1    one-cycle pulse in MOVE
// BEHAVIOUR
//  Reset (reset_n=0 at clock edge): state IDLE; all outputs 0; position, directions, colour, stop_pending,
//    pixel counter and divider all 0. Overrides every other input, including mid-DRAW/ERASE.
//  States: IDLE -> DRAW -> WAIT -> ERASE -> MOVE -> DRAW ... ; ERASE -> IDLE when stop_pending.
//  IDLE: load=1 latches inputs. x clamped to SCREEN_W-BOX_W, y clamped to SCREEN_H-BOX_H.
//    go=1 -> DRAW next cycle. load+go in the same cycle: latch, and DRAW uses the new values.
//  DRAW: BOX_W*BOX_H cycles, one pixel per cycle; plot=1, colour_out=sprite colour.
//    Sweep order: x inner, y outer. Pixel k: x_out = x_pos + k%BOX_W, y_out = y_pos + k/BOX_W.
//  WAIT: plot=0; divider cleared on entry; lasts exactly FRAMES_PER_STEP*FRAME_DIV cycles.
//  ERASE: same sweep as DRAW, colour_out=BG_COLOUR. Exits to IDLE if stop_pending (position kept,
//    stop_pending cleared), otherwise to MOVE.
//  MOVE: 1 cycle, plot=0, step_pulse=1. Each axis steps by 1 in its direction:
//    wrap: +x at SCREEN_W-BOX_W -> 0; -x at 0 -> SCREEN_W-BOX_W (y likewise with SCREEN_H-BOX_H).
//    bounce: a step that would leave [0, max] flips that axis direction and moves 1 the other way.
//  stop: sampled every cycle while busy; sets stop_pending. stop in IDLE is ignored.
//  go and load outside IDLE are ignored.
//  Outputs are registered: x_out/y_out/colour_out/plot change on the clock edge after the state decision.
//  x_out/y_out hold their last values when plot=0.
//  Step period = 2*BOX_W*BOX_H + FRAMES_PER_STEP*FRAME_DIV + 1 cycles.
//  Pixel counter width: $clog2(BOX_W*BOX_H). Divider width: $clog2(FRAME_DIV).
// TESTING (bench params: SCREEN_W=16, SCREEN_H=8, BOX_W=2, BOX_H=2, FRAME_DIV=4, FRAMES_PER_STEP=2)
//  1. Reset held 2 cycles -> plot=0, busy=0, x_out=0, y_out=0, step_pulse=0.
//  2. load x=3,y=2,colour=100,dirs=0, then go -> 4 plot cycles (3,2),(4,2),(3,3),(4,3) colour 100;
//     8 cycles plot=0; 4 plots at the same pixels with colour 000; step_pulse; redraw at (4,3).
//  3. Wrap: mode=0, x=14, +x -> next draw at x=0. Load x=20 -> clamped, first draw at x=14.
//  4. Bounce: mode=1, x=14 +x, y=6 +y -> next draw at (13,5), directions flipped; following draw at (12,4).
//  5. stop pulse during WAIT -> ERASE completes, no step_pulse, busy falls. A later go redraws at the same position.
//  6. reset_n low on the 2nd DRAW pixel -> next cycle plot=0, busy=0; a subsequent go draws at (0,0).

Source files
------------

// File: rtl/sprite_animator.sv
// Box-sprite animator: draw, hold for a number of frame ticks, erase, step one pixel per axis.
// Pixel outputs are registered from the next-state decision, so they line up with the state they describe.
module sprite_animator #(
  parameter int X_W             = 8,
  parameter int Y_W             = 7,
  parameter int SCREEN_W        = 160,
  parameter int SCREEN_H        = 120,
  parameter int BOX_W           = 4,
  parameter int BOX_H           = 4,
  parameter int FRAME_DIV       = 833334,
  parameter int FRAMES_PER_STEP = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           load,
  input  logic           go,
  input  logic           stop,
  input  logic           mode,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic [2:0]     colour_in,
  input  logic           x_dir_in,
  input  logic           y_dir_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [2:0]     colour_out,
  output logic           plot,
  output logic           busy,
  output logic           step_pulse
);

  localparam int NPIX  = BOX_W * BOX_H;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int COL_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int ROW_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int FRM_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - BOX_W);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - BOX_H);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BOX_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_STEP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_MOVE
  } state_t;

  state_t           state, state_nxt;
  logic [X_W-1:0]   x_pos, x_pos_nxt;
  logic [Y_W-1:0]   y_pos, y_pos_nxt;
  logic             x_dir, x_dir_nxt;
  logic             y_dir, y_dir_nxt;
  logic [2:0]       colour, colour_nxt;
  logic             stop_pending, stop_pending_nxt;
  logic [PIX_W-1:0] pix, pix_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [FRM_W-1:0] frm_cnt, frm_cnt_nxt;
  logic             last_pix;
  logic             plot_nxt;

  assign last_pix = (pix == PIX_LAST);
  assign plot_nxt = (state_nxt == S_DRAW) || (state_nxt == S_ERASE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      x_pos        <= '0;
      y_pos        <= '0;
      x_dir        <= 1'b0;
      y_dir        <= 1'b0;
      colour       <= '0;
      stop_pending <= 1'b0;
      pix          <= '0;
      col          <= '0;
      row          <= '0;
      div_cnt      <= '0;
      frm_cnt      <= '0;
      x_out        <= '0;
      y_out        <= '0;
      colour_out   <= '0;
      plot         <= 1'b0;
      busy         <= 1'b0;
      step_pulse   <= 1'b0;
    end else begin
      state        <= state_nxt;
      x_pos        <= x_pos_nxt;
      y_pos        <= y_pos_nxt;
      x_dir        <= x_dir_nxt;
      y_dir        <= y_dir_nxt;
      colour       <= colour_nxt;
      stop_pending <= stop_pending_nxt;
      pix          <= pix_nxt;
      col          <= col_nxt;
      row          <= row_nxt;
      div_cnt      <= div_cnt_nxt;
      frm_cnt      <= frm_cnt_nxt;
      plot         <= plot_nxt;
      busy         <= (state_nxt != S_IDLE);
      step_pulse   <= (state_nxt == S_MOVE);
      // Coordinates and colour hold their last value while not plotting.
      if (plot_nxt) begin
        x_out      <= x_pos_nxt + X_W'(col_nxt);
        y_out      <= y_pos_nxt + Y_W'(row_nxt);
        colour_out <= (state_nxt == S_DRAW) ? colour_nxt : BG_COLOUR;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    x_pos_nxt        = x_pos;
    y_pos_nxt        = y_pos;
    x_dir_nxt        = x_dir;
    y_dir_nxt        = y_dir;
    colour_nxt       = colour;
    stop_pending_nxt = stop_pending | (stop && (state != S_IDLE));
    pix_nxt          = pix;
    col_nxt          = col;
    row_nxt          = row;
    div_cnt_nxt      = div_cnt;
    frm_cnt_nxt      = frm_cnt;

    // Sweep counters advance in DRAW/ERASE and fall back to zero after the last pixel.
    if ((state == S_DRAW) || (state == S_ERASE)) begin
      if (last_pix) begin
        pix_nxt = '0;
        col_nxt = '0;
        row_nxt = '0;
      end else begin
        pix_nxt = pix + PIX_W'(1);
        if (col == COL_LAST) begin
          col_nxt = '0;
          row_nxt = row + ROW_W'(1);
        end else begin
          col_nxt = col + COL_W'(1);
        end
      end
    end

    case (state)
      S_IDLE: begin
        if (load) begin
          x_pos_nxt  = (x_in > X_MAX) ? X_MAX : x_in;
          y_pos_nxt  = (y_in > Y_MAX) ? Y_MAX : y_in;
          colour_nxt = colour_in;
          x_dir_nxt  = x_dir_in;
          y_dir_nxt  = y_dir_in;
        end
        if (go) state_nxt = S_DRAW;
      end

      S_DRAW: begin
        if (last_pix) begin
          state_nxt   = S_WAIT;
          div_cnt_nxt = '0;
          frm_cnt_nxt = '0;
        end
      end

      S_WAIT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (frm_cnt == FRM_LAST) state_nxt = S_ERASE;
          else                     frm_cnt_nxt = frm_cnt + FRM_W'(1);
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      S_ERASE: begin
        if (last_pix) begin
          if (stop_pending_nxt) begin
            state_nxt        = S_IDLE;
            stop_pending_nxt = 1'b0;
          end else begin
            state_nxt = S_MOVE;
          end
        end
      end

      S_MOVE: begin
        state_nxt = S_DRAW;
        if (!mode) begin
          if (!x_dir) x_pos_nxt = (x_pos >= X_MAX) ? '0 : x_pos + X_ONE;
          else        x_pos_nxt = (x_pos == '0) ? X_MAX : x_pos - X_ONE;
          if (!y_dir) y_pos_nxt = (y_pos >= Y_MAX) ? '0 : y_pos + Y_ONE;
          else        y_pos_nxt = (y_pos == '0) ? Y_MAX : y_pos - Y_ONE;
        end else begin
          // Bounce: a blocked step reverses the axis and moves one pixel back.
          if (!x_dir) begin
            if (x_pos >= X_MAX) begin
              x_dir_nxt = 1'b1;
              x_pos_nxt = (X_MAX == '0) ? '0 : X_MAX - X_ONE;
            end else begin
              x_pos_nxt = x_pos + X_ONE;
            end
          end else begin
            if (x_pos == '0) begin
              x_dir_nxt = 1'b0;
              x_pos_nxt = (X_MAX == '0) ? '0 : X_ONE;
            end else begin
              x_pos_nxt = x_pos - X_ONE;
            end
          end
          if (!y_dir) begin
            if (y_pos >= Y_MAX) begin
              y_dir_nxt = 1'b1;
              y_pos_nxt = (Y_MAX == '0) ? '0 : Y_MAX - Y_ONE;
            end else begin
              y_pos_nxt = y_pos + Y_ONE;
            end
          end else begin
            if (y_pos == '0) begin
              y_dir_nxt = 1'b0;
              y_pos_nxt = (Y_MAX == '0) ? '0 : Y_ONE;
            end else begin
              y_pos_nxt = y_pos - Y_ONE;
            end
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
